// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared constants and types for the instruction fetch controller
package fetch_pkg;

    localparam int LAT_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [LAT_W-1:0] lat_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - instruction memory bus and decode handshake bundle
interface instr_fetch_ctrl_if;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_address, instr_out, pc_out, instr_valid,
    input  mem_instruction, instr_ready
  );

  modport slave (
    input  mem_address, instr_out, pc_out, instr_valid,
    output mem_instruction, instr_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl_counter.sv
// rtl/instr_fetch_ctrl_counter.sv - loadable down-counter timing the memory settle window
module fetch_latency_counter
  import fetch_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i && count_q != '0)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencer that waits out memory latency and hands words to decode
// Optional misaligned-redirect fault output under FETCH_ALIGN_CHECK_EN.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          MEM_LATENCY = 4,
  parameter logic [31:0] PC_STEP     = PC_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic                 busy,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                 align_fault,
`endif
  instr_fetch_ctrl_if.master   bus
);

  localparam lat_t LAT_RELOAD = lat_t'(MEM_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcout_q, pcout_d;
  logic        valid_q, valid_d;
  logic        cnt_load, cnt_dec, cnt_done;
  logic        go;
  logic [31:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign go  = en && !fault_q;
  assign tgt = branch_target;
`else
  assign go  = en;
  assign tgt = branch_target & ~32'h3;
`endif

  fetch_latency_counter #(.W(LAT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (LAT_RELOAD),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcout_d  = pcout_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d  = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          instr_d = bus.mem_instruction;
          pcout_d = pc_q;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_VALID: begin
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_q + PC_STEP;
          if (go) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides everything above, including a same-edge transfer.
    if (branch_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (branch_target[1:0] != 2'b00) begin
        fault_d  = 1'b1;
        state_d  = ST_IDLE;
        valid_d  = 1'b0;
        pc_d     = pc_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
      end else
`endif
      begin
        pc_d = tgt;
        if (state_q != ST_IDLE) begin
          valid_d  = 1'b0;
          cnt_dec  = 1'b0;
          cnt_load = go;
          state_d  = go ? ST_WAIT : ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_q <= 1'b0;
    else
      fault_q <= fault_d;
  end
  assign align_fault = fault_q;
`endif

  assign bus.mem_address = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pcout_q;
  assign bus.instr_valid = valid_q;
  assign busy            = (state_q == ST_WAIT) || (state_q == ST_VALID);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en1;
  logic        br;
  logic [31:0] tgt;
  logic        busy0, busy1;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        af0, af1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  instr_fetch_ctrl_if b0();
  instr_fetch_ctrl_if b1();

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.RESET_PC(32'h0), .MEM_LATENCY(4), .PC_STEP(32'd4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .branch_taken(br), .branch_target(tgt),
    .busy(busy0),
`ifdef FETCH_ALIGN_CHECK_EN
    .align_fault(af0),
`endif
    .bus(b0.master)
  );

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(4), .PC_STEP(32'd4)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .branch_taken(1'b0), .branch_target(32'h0),
    .busy(busy1),
`ifdef FETCH_ALIGN_CHECK_EN
    .align_fault(af1),
`endif
    .bus(b1.master)
  );

  // Slow memory: word is garbage until the address has been stable long enough.
  logic [31:0] last0, last1;
  int age0 = 0, age1 = 0;
  initial begin
    b0.mem_instruction = 32'hBADB_AD00;
    b1.mem_instruction = 32'hBADB_AD00;
    last0 = 32'h0;
    last1 = 32'hFFFF_FFFC;
  end
  always @(negedge clk) begin
    if (b0.mem_address !== last0) begin last0 = b0.mem_address; age0 = 0; end
    else if (age0 < 15) age0++;
    b0.mem_instruction = (age0 >= 3) ? last0 + 32'hA000_0000 : 32'hBADB_AD00;
    if (b1.mem_address !== last1) begin last1 = b1.mem_address; age1 = 0; end
    else if (age1 < 15) age1++;
    b1.mem_instruction = (age1 >= 3) ? last1 + 32'hA000_0000 : 32'hBADB_AD00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!b0.instr_valid && n < 30);
    if (!b0.instr_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid: timeout after %0d cycles", n);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && b0.instr_valid && b0.instr_ready) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL sb0_unexpected: got pc %h instr %h expected none", b0.pc_out, b0.instr_out);
      end else begin
        e = q0.pop_front();
        if ({b0.pc_out, b0.instr_out} !== e) begin
          n_bad++;
          $display("FAIL sb0_xfer: got %h_%h expected %h_%h", b0.pc_out, b0.instr_out, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && b1.instr_valid && b1.instr_ready) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL sb1_unexpected: got pc %h instr %h expected none", b1.pc_out, b1.instr_out);
      end else begin
        e = q1.pop_front();
        if ({b1.pc_out, b1.instr_out} !== e) begin
          n_bad++;
          $display("FAIL sb1_xfer: got %h_%h expected %h_%h", b1.pc_out, b1.instr_out, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; en1 = 1'b0; br = 1'b0; tgt = 32'h0;
    b0.instr_ready = 1'b0; b1.instr_ready = 1'b0;
    #12;
    check("rst_valid", {31'h0, b0.instr_valid}, 32'h0);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_addr", b0.mem_address, 32'h0);
    check("rst_addr1", b1.mem_address, 32'hFFFF_FFFC);
    check("rst_pc_out", b0.pc_out, 32'h0);
    check("rst_instr_out", b0.instr_out, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", {31'h0, busy0}, 32'h0);
    check("idle_valid", {31'h0, b0.instr_valid}, 32'h0);

    // Sequential fetch; dut1 exercises wrap from FFFF_FFFC
    q0.push_back({32'h0, 32'hA000_0000});
    q0.push_back({32'h4, 32'hA000_0004});
    q0.push_back({32'h8, 32'hA000_0008});
    q1.push_back({32'hFFFF_FFFC, 32'h9FFF_FFFC});
    q1.push_back({32'h0000_0000, 32'hA000_0000});
    @(negedge clk);
    en = 1'b1; en1 = 1'b1; b0.instr_ready = 1'b1; b1.instr_ready = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("t1_early_valid", {31'h0, b0.instr_valid}, 32'h0);
    check("t1_wait_busy", {31'h0, busy0}, 32'h1);
    @(posedge clk); #1;
    check("t1_first_valid", {31'h0, b0.instr_valid}, 32'h1);
    check("t1_first_pc", b0.pc_out, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("t1_gap_valid", {31'h0, b0.instr_valid}, 32'h0);
    @(posedge clk); #1;
    check("t1_second_valid", {31'h0, b0.instr_valid}, 32'h1);
    check("t1_second_pc", b0.pc_out, 32'h4);

    // Backpressure on pc 4
    b0.instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin b1.instr_ready = 1'b0; en1 = 1'b0; end
      check("t2_hold_valid", {31'h0, b0.instr_valid}, 32'h1);
      check("t2_hold_pc", b0.pc_out, 32'h4);
      check("t2_hold_instr", b0.instr_out, 32'hA000_0004);
      check("t2_hold_addr", b0.mem_address, 32'h4);
    end
    b0.instr_ready = 1'b1;
    wait_valid(n);
    check("t2_release_lat", n, 5);
    check("t2_next_pc", b0.pc_out, 32'h8);

    // Redirect while fetching 0xC: 0xC must never be delivered
    q0.push_back({32'h40, 32'hA000_0040});
    @(posedge clk); #1;
    check("t3_in_wait", {31'h0, busy0 & ~b0.instr_valid}, 32'h1);
    br = 1'b1; tgt = 32'h40;
    @(posedge clk); #1;
    br = 1'b0;
    check("t3_redir_addr", b0.mem_address, 32'h40);
    wait_valid(n);
    check("t3_redir_lat", n, 4);
    check("t3_redir_pc", b0.pc_out, 32'h40);

    // Transfer of 0x44 coincides with branch to 0x100
    q0.push_back({32'h44, 32'hA000_0044});
    q0.push_back({32'h100, 32'hA000_0100});
    wait_valid(n);
    check("t4_pc44", b0.pc_out, 32'h44);
    br = 1'b1; tgt = 32'h100;
    @(posedge clk); #1;
    br = 1'b0;
    check("t4_consumed", {31'h0, b0.instr_valid}, 32'h0);
    check("t4_addr", b0.mem_address, 32'h100);
    wait_valid(n);
    check("t4_lat", n, 4);
    check("t4_pc", b0.pc_out, 32'h100);

    // Async reset in the middle of the 0x104 fetch
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("t6_pre_busy", {31'h0, busy0}, 32'h1);
    check("t6_pre_addr", b0.mem_address, 32'h104);
    check("t5_wrap_drained", q1.size(), 0);
    rst = 1'b1;
    #1;
    check("t6_valid", {31'h0, b0.instr_valid}, 32'h0);
    check("t6_busy", {31'h0, busy0}, 32'h0);
    check("t6_addr", b0.mem_address, 32'h0);
    check("t6_sb_drained", q0.size(), 0);

`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk) rst = 1'b0;
    en = 1'b1; br = 1'b1; tgt = 32'h42;
    @(posedge clk); #1;
    br = 1'b0;
    check("af_set", {31'h0, af0}, 32'h1);
    check("af_addr", b0.mem_address, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("af_idle_busy", {31'h0, busy0}, 32'h0);
    check("af_idle_valid", {31'h0, b0.instr_valid}, 32'h0);
    check("af_sticky", {31'h0, af0}, 32'h1);
    rst = 1'b1; #1;
    check("af_cleared", {31'h0, af0}, 32'h0);
`endif

    en = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
